// File: rtl/player_bullet_controller.sv
// Player bullet pool: eight registered slots, fire edge detection with a
// cooldown, upward movement on a divided tick, and per-slot hit clearing.

// One bullet slot: spawn, move on tick, retire on hit or at the screen top.
module bullet_slot #(
   parameter int SPEED = 4
) (
   input  logic       clk25,
   input  logic       rst,
   input  logic       clear,
   input  logic       tick,
   input  logic       hit,
   input  logic       spawn,
   input  logic [9:0] spawn_x,
   input  logic [9:0] spawn_y,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active
);
   localparam logic [9:0] SPD = 10'(SPEED);

   // Slot state; a hit beats movement, and x/y hold their last value once retired.
   always_ff @(posedge clk25) begin
      if (rst) begin
         x      <= '0;
         y      <= '0;
         active <= 1'b0;
      end else if (clear) begin
         active <= 1'b0;
      end else if (spawn) begin
         x      <= spawn_x;
         y      <= spawn_y;
         active <= 1'b1;
      end else if (active) begin
         if (hit)
            active <= 1'b0;
         else if (tick) begin
            if (y >= SPD) y <= y - SPD;
            else          active <= 1'b0;
         end
      end
   end
endmodule

module player_bullet_controller #(
   parameter int MOVE_DIV = 250_000,
   parameter int SPEED    = 4,
   parameter int COOLDOWN = 20
) (
   input  logic        clk25,
   input  logic        rst,
   input  logic        enable,
   input  logic        fire,
   input  logic [9:0]  player_x,
   input  logic [9:0]  player_y,
   input  logic [7:0]  bullet_hit,
   output logic [79:0] bullet_x_flat,
   output logic [79:0] bullet_y_flat,
   output logic [7:0]  bullet_active_flat,
   output logic        shot_fired,
   output logic [3:0]  active_count
);
   localparam int NUM_SLOTS = 8;
   localparam int DIV_W = (MOVE_DIV > 2) ? $clog2(MOVE_DIV) : 1;
   localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

   logic [DIV_W-1:0]     div;
   logic                 tick;
   logic                 fire_q;
   logic                 fire_held_rst;
   logic                 req;
   logic                 accept;
   logic [CD_W-1:0]      cd;
   logic [NUM_SLOTS-1:0] free;
   logic [NUM_SLOTS-1:0] grant;
   logic [9:0]           spawn_x;
   logic [9:0]           spawn_y;
   logic [3:0]           pop;

   assign tick = (div == DIV_W'(MOVE_DIV - 1));

   // Free-running movement divider; runs regardless of enable.
   always_ff @(posedge clk25) begin
      if (rst)       div <= '0;
      else if (tick) div <= '0;
      else           div <= div + DIV_W'(1);
   end

   // Fire edge register. It is cleared by reset, so fire_held_rst remembers
   // that fire was high at the last reset edge; a button held through reset
   // then does not count as a fresh press when reset releases.
   always_ff @(posedge clk25) begin
      if (rst) begin
         fire_q        <= 1'b0;
         fire_held_rst <= fire;
      end else begin
         fire_q        <= fire;
         fire_held_rst <= 1'b0;
      end
   end

   // Slot choice uses flags from the start of the cycle, so a slot retired
   // this cycle only becomes eligible next cycle.
   assign req     = fire & ~fire_q & ~fire_held_rst;
   assign free    = ~bullet_active_flat;
   assign grant   = free & (~free + 8'd1);
   assign accept  = enable & req & (cd == '0) & (|free);
   assign spawn_x = player_x + 10'd12;
   assign spawn_y = (player_y < 10'd8) ? 10'd0 : player_y - 10'd8;

   // Cooldown in ticks: loaded on an accepted shot, counts down on tick.
   always_ff @(posedge clk25) begin
      if (rst || !enable)     cd <= '0;
      else if (accept)        cd <= CD_W'(COOLDOWN);
      else if (tick && cd != '0) cd <= cd - CD_W'(1);
   end

   // Shot pulse, one cycle after acceptance.
   always_ff @(posedge clk25) begin
      if (rst) shot_fired <= 1'b0;
      else     shot_fired <= accept;
   end

   // Popcount of the current flags; the registered copy lags them by a cycle.
   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_SLOTS; i++) pop = pop + {3'b0, bullet_active_flat[i]};
   end

   // Registered active count.
   always_ff @(posedge clk25) begin
      if (rst) active_count <= '0;
      else     active_count <= pop;
   end

   genvar g;
   generate
      for (g = 0; g < NUM_SLOTS; g++) begin : g_slot
         bullet_slot #(.SPEED(SPEED)) u_slot (
            .clk25   (clk25),
            .rst     (rst),
            .clear   (~enable),
            .tick    (tick),
            .hit     (bullet_hit[g]),
            .spawn   (accept & grant[g]),
            .spawn_x (spawn_x),
            .spawn_y (spawn_y),
            .x       (bullet_x_flat[g*10 +: 10]),
            .y       (bullet_y_flat[g*10 +: 10]),
            .active  (bullet_active_flat[g])
         );
      end
   endgenerate
endmodule

// File: doc/player_bullet_controller.md
PLAYER_BULLET_CONTROLLER -- requirements
Module: player_bullet_controller

Interface
REQ-001 SHALL expose parameter MOVE_DIV, default 250_000, clk25 cycles per movement tick.
REQ-002 SHALL expose parameter SPEED, default 4, pixels moved upward per tick.
REQ-003 SHALL expose parameter COOLDOWN, default 20, ticks after a shot before the next shot is accepted.
REQ-004 SHALL have port clk25  input  1  sole clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port enable  input  1  gameplay active; low clears the bullet pool.
REQ-007 SHALL have port fire  input  1  debounced fire button level.
REQ-008 SHALL have ports player_x, player_y  input  10 each  top-left of the 32x32 player sprite.
REQ-009 SHALL have port bullet_hit  input  8  per-slot hit pulses, OR of all enemy controllers.
REQ-010 SHALL have ports bullet_x_flat, bullet_y_flat  output  80 each  slot i at bits [i*10 +: 10].
REQ-011 SHALL have port bullet_active_flat  output  8  bit i set when slot i is in flight.
REQ-012 SHALL have port shot_fired  output  1  one-cycle pulse on each accepted shot.
REQ-013 SHALL have port active_count  output  4  number of set bits in bullet_active_flat, range 0-8.

Function
REQ-014 SHALL hold 8 bullet slots, each 10-bit x, 10-bit y and an active flag, all registered.
REQ-015 SHALL generate tick as a one-cycle pulse when a free-running divider reaches MOVE_DIV-1; the divider then wraps to 0.
REQ-016 SHALL detect a fire request as fire=1 with the fire value registered on the previous cycle equal to 0; holding fire produces one request.
REQ-017 SHALL accept a request only when enable=1, cooldown=0, and at least one slot was inactive at the start of the cycle.
REQ-018 SHALL place an accepted shot in the lowest-index inactive slot, with x=player_x+12, y=player_y-8 and active=1.
REQ-019 SHALL set y=0 on spawn when player_y<8, so y does not underflow.
REQ-020 SHALL assert shot_fired in the cycle after acceptance and load cooldown with COOLDOWN.
REQ-021 SHALL drop a request with no free slot or nonzero cooldown silently: no pulse and no cooldown load.
REQ-022 SHALL decrement cooldown by 1 on each tick while it is nonzero, saturating at 0.
REQ-023 SHALL, on tick, decrease y by SPEED for each active slot with y>=SPEED, and clear active for any active slot with y<SPEED.
REQ-024 SHALL clear slot i's active flag on the next edge when bullet_hit[i]=1, regardless of tick.
REQ-025 SHALL let a hit take priority over movement in the same cycle.
REQ-026 SHALL ignore bullet_hit on an inactive slot.
REQ-027 SHALL not allow a slot freed by hit or by leaving the screen to take a spawn in the same cycle; it is eligible from the next cycle.
REQ-028 SHALL not move a slot spawned in the same cycle as a tick until the following tick.
REQ-029 SHALL, while enable=0, clear all active flags, cooldown and shot_fired, keep the divider running and keep tracking the fire edge register.
REQ-030 SHALL keep x/y of inactive slots at their last values; consumers qualify x/y with active.
REQ-031 SHALL update active_count one cycle after the active flags change, as a registered popcount.

Reset
REQ-032 SHALL, with rst=1 at a rising edge, clear all active flags, all x/y, cooldown, the divider, the fire edge register, shot_fired and active_count to 0.
REQ-033 SHALL give rst priority over enable, fire, tick and bullet_hit; reset mid-flight discards all bullets.
REQ-034 SHALL block a shot in the first cycle after rst deasserts if fire is held high throughout reset, since no rising edge occurs.

Verification
REQ-035 Run with MOVE_DIV=4, SPEED=4, COOLDOWN=2, player at (300,400), and a fire rising edge. Required: slot 0 x=312, y=392, active; shot_fired pulses once; y reads 388 after the next tick.
REQ-036 Run with cooldown expired between shots and 9 fire edges. Required: slots 0-7 fill in order; the 9th edge is dropped with no shot_fired; active_count=8.
REQ-037 Run with slots 0 and 3 active and bullet_hit=8'b0000_1001 on a tick cycle. Required: both slots inactive next cycle, their y unchanged, and the next shot lands in slot 0.
REQ-038 Spawn with player_y=10, then apply ticks. Required: y sequence 2, then active cleared on the next tick (2<4).
REQ-039 Fire edge 1 tick after a shot with COOLDOWN=2. Required: dropped. Fire edge after 2 ticks: accepted.
REQ-040 Drop enable mid-flight, and separately pulse rst with 5 bullets active. Required: bullet_active_flat=0 next cycle and active_count=0 one cycle later in both cases.
